xrv_mult_ctrl: RTL and testbench

//  Sequencer between the execute stage and the shared 16x16-DSP multiplier (4-pass, multi-cycle).

---
 rtl/xrv_mult_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_xrv_mult_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrv_mult_ctrl.sv
// -----------------------------------------------------------------------------
// xrv_mult_ctrl
//
// Sequencer between the execute stage and the shared multi-cycle multiplier.
// Takes one M-extension multiply (MUL/MULH/MULHSU/MULHU) over a valid/ready
// request port. It issues the multiply with a one-cycle strobe and holds the
// operands stable while the multiplier works. It then waits for the result
// under a watchdog and returns the result with its rd tag over a valid/ready
// response port. Flushes kill in-flight or pending work. An op that is already
// issued is drained, because the multiplier cannot abort.
//
// Optional build macro:
//   XRV_MULT_CACHE_EN - adds a single-entry result cache. A request that
//                       matches the last successfully completed a/b/type
//                       is answered from the cache without using the
//                       multiplier.
//
// Parameters:
//   TIMEOUT  max cycles spent in WAIT/DRAIN before the watchdog aborts (>=8)
//   CW       watchdog counter width, 2**CW > TIMEOUT
//
// Ports:
//   clk, rstb                       clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_type, req_rd  operands, funct3, destination tag
//   flush                           kill in-flight / pending op
//   mult_valid                      one-cycle issue strobe to the multiplier
//   mult_a, mult_b, mult_type       operands held for the multiplier
//   mult_result, mult_rvalid        result and result strobe from the multiplier
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_rd, rsp_err       result (0 on error), tag, watchdog abort
//   busy                            controller not idle
// -----------------------------------------------------------------------------
module xrv_mult_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [2:0]  req_type,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        mult_valid,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic [2:0]  mult_type,
   input  logic [31:0] mult_result,
   input  logic        mult_rvalid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

   state_e        state_q, state_d;
   logic [CW-1:0] wd_q, wd_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [2:0]    type_q, type_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;

   logic          req_ready_c;
   logic          accept_c;
   logic          wd_limit_c;

   // Compared with >= so that a flush that arrives exactly at the limit
   // still exits DRAIN on the next cycle instead of waiting for a wrap.
   assign wd_limit_c = (wd_q >= WD_LIMIT);

`ifdef XRV_MULT_CACHE_EN
   logic          cache_vld_q;
   logic [31:0]   cache_a_q;
   logic [31:0]   cache_b_q;
   logic [2:0]    cache_type_q;
   logic [31:0]   cache_res_q;
   logic          hit_q;
   logic          cache_hit_c;
   logic          cache_upd_c;
   logic          cache_inv_c;

   assign cache_hit_c = cache_vld_q && (req_a == cache_a_q) &&
                        (req_b == cache_b_q) && (req_type == cache_type_q);
   // Fill only on a genuine result that is returned (WAIT->RESP, no error).
   assign cache_upd_c = (state_q == ST_WAIT) && !flush && mult_rvalid;
   // Any watchdog abort makes the multiplier state suspect, so drop the entry.
   assign cache_inv_c = !mult_rvalid && wd_limit_c &&
                        (((state_q == ST_WAIT) && !flush) || (state_q == ST_DRAIN));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cache_vld_q  <= 1'b0;
         cache_a_q    <= '0;
         cache_b_q    <= '0;
         cache_type_q <= '0;
         cache_res_q  <= '0;
         hit_q        <= 1'b0;
      end else begin
         if (cache_upd_c) begin
            cache_vld_q  <= 1'b1;
            cache_a_q    <= a_q;
            cache_b_q    <= b_q;
            cache_type_q <= type_q;
            cache_res_q  <= mult_result;
         end else if (cache_inv_c) begin
            cache_vld_q  <= 1'b0;
         end
         if (accept_c) begin
            hit_q <= cache_hit_c;
         end
      end
   end

   // A cache hit passes through ISSUE without strobing the multiplier.
   assign mult_valid = (state_q == ST_ISSUE) && !hit_q;
`else
   assign mult_valid = (state_q == ST_ISSUE);
`endif

   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      a_d         = a_q;
      b_d         = b_q;
      type_d      = type_q;
      rd_d        = rd_q;
      data_d      = data_q;
      err_d       = err_q;
      req_ready_c = 1'b0;
      accept_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready_c = ~flush;
         end
         ST_ISSUE: begin
            wd_d = '0;
`ifdef XRV_MULT_CACHE_EN
            if (hit_q) begin
               // Nothing was sent to the multiplier, so a flush has nothing to drain.
               state_d = flush ? ST_IDLE : ST_RESP;
            end else begin
               state_d = flush ? ST_DRAIN : ST_WAIT;
            end
`else
            // The strobe has already gone out this cycle; a flush must drain it.
            state_d = flush ? ST_DRAIN : ST_WAIT;
`endif
         end
         ST_WAIT: begin
            if (!wd_limit_c) begin
               wd_d = wd_q + 1'b1;
            end
            if (flush) begin
               state_d = ST_DRAIN;
            end else if (mult_rvalid) begin
               data_d  = mult_result;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (wd_limit_c) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (rsp_ready) begin
               // The response leaves this cycle, so a new op can enter on the
               // same edge.
               req_ready_c = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!wd_limit_c) begin
               wd_d = wd_q + 1'b1;
            end
            if (mult_rvalid || wd_limit_c) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      accept_c = req_ready_c & req_valid;
      if (accept_c) begin
         a_d     = req_a;
         b_d     = req_b;
         type_d  = req_type;
         rd_d    = req_rd;
         state_d = ST_ISSUE;
`ifdef XRV_MULT_CACHE_EN
         if (cache_hit_c) begin
            data_d = cache_res_q;
            err_d  = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         wd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         type_q  <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         type_q  <= type_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = req_ready_c;
   assign mult_a    = a_q;
   assign mult_b    = b_q;
   assign mult_type = type_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = data_q;
   assign rsp_rd    = rd_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xrv_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xrv_mult_ctrl
//
// Scoreboard bench for xrv_mult_ctrl. The request driver pushes the expected
// response (computed from the RISC-V multiply definition) when a request is
// accepted. An independent monitor pops and compares it at each response
// handshake. The multiplier is modelled with a fixed latency of LAT cycles and
// can be told to stay silent so the watchdog fires.
// -----------------------------------------------------------------------------
module tb_xrv_mult_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CW      = 5;
   localparam int LAT     = 5;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        req_valid, req_ready;
   logic [31:0] req_a, req_b;
   logic [2:0]  req_type;
   logic [4:0]  req_rd;
   logic        flush;
   logic        mult_valid;
   logic [31:0] mult_a, mult_b;
   logic [2:0]  mult_type;
   logic [31:0] mult_result;
   logic        mult_rvalid;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        busy;

   always #5 clk = ~clk;

   xrv_mult_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk(clk), .rstb(rstb),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_type(req_type), .req_rd(req_rd),
      .flush(flush),
      .mult_valid(mult_valid), .mult_a(mult_a), .mult_b(mult_b), .mult_type(mult_type),
      .mult_result(mult_result), .mult_rvalid(mult_rvalid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
      .busy(busy)
   );

   typedef struct packed {
      logic        err;
      logic [4:0]  rd;
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   rr_rand = 1'b0;
   bit   silent  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // RISC-V M-extension multiply, computed modulo 2**64 on extended operands.
   function automatic logic [31:0] ref_mul(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, p;
      sa = {{32{a[31]}}, a};
      ua = {32'd0, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      case (t)
         3'd0:    begin p = ua * ub; return p[31:0];  end
         3'd1:    begin p = sa * sb; return p[63:32]; end
         3'd2:    begin p = sa * ub; return p[63:32]; end
         3'd3:    begin p = ua * ub; return p[63:32]; end
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Multiplier model: answers LAT cycles after the strobe, using the live
   // held operands and type, so any disturbance of them corrupts the result.
   int mcnt = 0;
   always @(negedge clk) begin
      if (!rstb) begin
         mcnt        = 0;
         mult_rvalid = 1'b0;
         mult_result = 32'd0;
      end else begin
         mult_rvalid = 1'b0;
         mult_result = $urandom;
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               mult_rvalid = 1'b1;
               mult_result = ref_mul(mult_type, mult_a, mult_b);
            end
         end
         if (mult_valid && !silent) mcnt = LAT;
      end
   end

   // Random writeback backpressure, applied only while enabled.
   always @(posedge clk) begin
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
   end

   // Response monitor.
   bit          stall_prev = 1'b0;
   logic [37:0] held_prev;
   always @(negedge clk) begin
      if (rstb) begin
         if (stall_prev && rsp_valid && !flush)
            check("rsp_hold", {rsp_err, rsp_rd, rsp_data}, held_prev);
         if (rsp_valid && !rsp_ready)
            check("req_ready_stall", req_ready, 1'b0);
         if (rsp_valid && rsp_ready && !flush) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_rsp: got data=0x%0h rd=%0d err=%0d, expected no response",
                        rsp_data, rsp_rd, rsp_err);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_content", {rsp_err, rsp_rd, rsp_data}, e);
            end
         end
         stall_prev = rsp_valid && !rsp_ready && !flush;
         held_prev  = {rsp_err, rsp_rd, rsp_data};
      end
   end

   task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit exp_err, output int acc);
      rsp_t e;
      acc       = -1;
      req_valid = 1'b1;
      req_type  = t;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            acc    = cyc;
            e.err  = exp_err;
            e.rd   = rd;
            e.data = exp_err ? 32'd0 : ref_mul(t, a, b);
            exp_q.push_back(e);
            #1;
            req_valid = 1'b0;
            req_a     = $urandom;
            req_b     = $urandom;
            req_rd    = 5'($urandom);
            return;
         end
      end
      req_valid = 1'b0;
      check("req_accept", req_ready, 1'b1);
   endtask

   // Counts negedges after the accepting edge: first mult_valid, first rsp_valid.
   task automatic after_accept(output int kmv, output int krsp);
      kmv  = -1;
      krsp = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (mult_valid && kmv < 0) kmv = k;
         if (rsp_valid) begin
            krsp = k;
            break;
         end
      end
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int acc, acc2, kmv, krsp;
      rsp_t dropped;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_type  = '0;
      req_rd    = '0;
      flush     = 1'b0;
      rsp_ready = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_mult_valid", mult_valid, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_mult_ab", {mult_a, mult_b}, 64'd0);
      check("rst_mult_type", mult_type, 3'd0);
      check("rst_rsp_data_rd", {rsp_rd, rsp_data}, 37'd0);
      @(posedge clk); #1 rstb = 1'b1;
      @(posedge clk); #1;

      // MUL 3*5 with latency checks.
      send(3'd0, 32'd3, 32'd5, 5'd7, 1'b0, acc);
      after_accept(kmv, krsp);
      check("mul_issue_lat", kmv, 1);
      check("mul_rsp_lat", krsp, LAT + 2);
      @(posedge clk); #1;

      // MULHU all-ones with 4 cycles of backpressure.
      rsp_ready = 1'b0;
      send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, acc);
      after_accept(kmv, krsp);
      check("mulhu_rsp_lat", krsp, LAT + 2);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("mulhu_req_ready", req_ready, 1'b0);
         check("mulhu_data", rsp_data, 32'hFFFF_FFFE);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Flush two cycles after issue: the op drains and is never answered.
      send(3'd0, 32'd7, 32'd9, 5'd3, 1'b0, acc);
      @(posedge clk); #1;
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      dropped = exp_q.pop_back();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("flush_no_rsp", rsp_valid, 1'b0);
      end
      check("flush_idle", busy, 1'b0);
      @(posedge clk); #1;
      send(3'd0, 32'd2, 32'd2, 5'd4, 1'b0, acc);
      after_accept(kmv, krsp);
      check("post_flush_lat", krsp, LAT + 2);
      @(posedge clk); #1;

      // Silent multiplier: watchdog abort.
      silent = 1'b1;
      send(3'd0, 32'h1234, 32'h5678, 5'd9, 1'b1, acc);
      after_accept(kmv, krsp);
      check("wd_issue_lat", kmv, 1);
      check("wd_rsp_lat", krsp, TIMEOUT + 3);
      @(posedge clk); #1;
      @(negedge clk);
      check("wd_busy_after_ack", busy, 1'b0);
      silent = 1'b0;
      @(posedge clk); #1;

      // Back-to-back: second op is taken on the edge the first response leaves.
      send(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 1'b0, acc);
      send(3'd2, 32'hFFFF_FFF0, 32'h0000_0010, 5'd22, 1'b0, acc2);
      check("b2b_gap", acc2 - acc, LAT + 2);
      after_accept(kmv, krsp);
      check("b2b_issue_lat", kmv, 1);
      check("b2b_rsp_lat", krsp, LAT + 2);
      @(posedge clk); #1;

      // Randomised traffic with random backpressure.
      rr_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send(3'($urandom_range(0, 3)), pick_op(), pick_op(), 5'($urandom), 1'b0, acc);
      end
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
      check("random_drained", exp_q.size(), 0);
      rr_rand = 1'b0;
      @(posedge clk); #2 rsp_ready = 1'b1;
      repeat (2) @(posedge clk); #1;

`ifdef XRV_MULT_CACHE_EN
      // Repeated MULH is served from the cache.
      send(3'd1, 32'h8000_0000, 32'h0000_0002, 5'd5, 1'b0, acc);
      after_accept(kmv, krsp);
      @(posedge clk); #1;
      send(3'd1, 32'h8000_0000, 32'h0000_0002, 5'd6, 1'b0, acc);
      after_accept(kmv, krsp);
      check("cache_no_issue", kmv, -1);
      check("cache_rsp_lat", krsp, 2);
      check("cache_data", rsp_data, 32'hFFFF_FFFF);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: got no completion, expected finish within time limit");
      $fatal(1, "simulation time limit reached");
   end

endmodule
